block_window_loader: RTL and testbench

BLOCK_WINDOW_LOADER -- requirements
Module: block_window_loader

---
 rtl/block_window_loader_pkg.sv | 41 ++++
 rtl/block_window_loader_mem_reader.sv | 40 ++++
 rtl/block_window_loader.sv | 188 ++++++++++++++++++
 tb/tb_block_window_loader.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/block_window_loader_pkg.sv
// Shared types and constants for the beatmap block window loader.
// Record layout (LSB first): time, x, y, z, color, direction, ID.
package block_window_loader_pkg;

   localparam int NUM_SLOTS = 12;
   localparam int TIME_W    = 18;
   localparam int X_W       = 12;
   localparam int Y_W       = 12;
   localparam int Z_W       = 14;
   localparam int DIR_W     = 3;
   localparam int ID_W      = 8;
   localparam int REC_W     = TIME_W + X_W + Y_W + Z_W + 1 + DIR_W + ID_W;

   // Packed MSB first, so the declaration order is the reverse of the memory layout.
   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [DIR_W-1:0]  direction;
      logic              color;
      logic [Z_W-1:0]    z;
      logic [Y_W-1:0]    y;
      logic [X_W-1:0]    x;
      logic [TIME_W-1:0] tstamp;
   } block_rec_t;

   typedef struct packed {
      logic [ID_W-1:0]  id;
      logic [DIR_W-1:0] direction;
      logic             color;
      logic [Z_W-1:0]   z;
      logic [Y_W-1:0]   y;
      logic [X_W-1:0]   x;
   } slot_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SKIP,
      S_FILL,
      S_PUBLISH
   } state_t;

endpackage

// File: rtl/block_window_loader_mem_reader.sv
// Issues one beatmap memory read and raises rec_valid for one cycle once
// MEM_LATENCY cycles have elapsed; a new start may coincide with rec_valid.
module block_mem_reader #(
   parameter int ADDR_W      = 8,
   parameter int MEM_LATENCY = 2
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              start,
   input  logic [ADDR_W-1:0] addr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              busy,
   output logic              rec_valid
);

   localparam int LAT_W = $clog2(MEM_LATENCY + 1);

   logic [LAT_W-1:0] wait_cnt;
   logic             pending;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         pending  <= 1'b0;
         wait_cnt <= '0;
         mem_addr <= '0;
      end else if (start) begin
         pending  <= 1'b1;
         wait_cnt <= LAT_W'(MEM_LATENCY);
         mem_addr <= addr;
      end else if (rec_valid) begin
         pending <= 1'b0;
      end else if (pending) begin
         wait_cnt <= wait_cnt - 1'b1;
      end
   end

   assign busy      = pending;
   assign rec_valid = pending && (wait_cnt == '0);

endmodule

// File: rtl/block_window_loader.sv
// Scans beatmap memory for blocks whose time lies in [t0, t0+WINDOW) and publishes
// up to 12 of them per frame. Define BLOCK_LOADER_STATS_EN for overrun/scan counters.
module block_window_loader
   import block_window_loader_pkg::*;
#(
   parameter int          NUM_BLOCKS  = 256,
   parameter int          ADDR_W      = 8,
   parameter logic [17:0] WINDOW      = 18'd4096,
   parameter int          MEM_LATENCY = 2
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  frame_start_in,
   input  logic [17:0]           curr_time_in,
   output logic [ADDR_W-1:0]     mem_addr_out,
   input  logic [67:0]           mem_data_in,
   output logic [11:0][11:0]     block_x_out,
   output logic [11:0][11:0]     block_y_out,
   output logic [11:0][13:0]     block_z_out,
   output logic [11:0]           block_color_out,
   output logic [11:0][2:0]      block_direction_out,
   output logic [11:0][7:0]      block_ID_out,
   output logic [11:0]           block_visible_out,
   output logic                  busy_out,
   output logic                  valid_out
`ifdef BLOCK_LOADER_STATS_EN
   ,
   output logic [15:0]           overrun_count_out,
   output logic [ADDR_W:0]       scanned_out
`endif
);

   localparam int              CNT_W    = $clog2(NUM_SLOTS + 1);
   localparam logic [ADDR_W:0] END_ADDR = (ADDR_W + 1)'(NUM_BLOCKS);

   state_t               state;
   logic [ADDR_W:0]      addr, head, nxt_addr;
   logic [CNT_W-1:0]     count;
   logic [TIME_W-1:0]    t0;
   logic [TIME_W:0]      t_end;
   slot_t                work [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] work_vis;
   block_rec_t           rec;
   logic                 rd_start, rd_busy, rec_valid, go_on, in_window, at_end;
`ifdef BLOCK_LOADER_STATS_EN
   logic [ADDR_W:0]      scan_cnt;
`endif

   assign rec       = block_rec_t'(mem_data_in);
   assign in_window = {1'b0, rec.tstamp} < t_end;
   assign at_end    = !rd_busy && (addr == END_ADDR);
   assign busy_out  = (state != S_IDLE);

   // Decide whether the next read can be issued in the same cycle the current
   // record is evaluated, so each record costs MEM_LATENCY+1 cycles.
   // NOTE: combinational logic uses blocking '=' and assigns every output a default first, so no latch is inferred.
   always_comb begin
      nxt_addr = addr;
      go_on    = 1'b0;
      if (state == S_SKIP || state == S_FILL) begin
         if (rec_valid) begin
            if (state == S_SKIP) begin
               go_on = 1'b1;
               if (rec.tstamp < t0) nxt_addr = addr + 1'b1;
            end else if (in_window && count != CNT_W'(NUM_SLOTS - 1)) begin
               go_on    = 1'b1;
               nxt_addr = addr + 1'b1;
            end
         end else if (!rd_busy) begin
            go_on = 1'b1;
         end
      end
      rd_start = go_on && (nxt_addr != END_ADDR);
   end

   block_mem_reader #(
      .ADDR_W      (ADDR_W),
      .MEM_LATENCY (MEM_LATENCY)
   ) u_reader (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .start     (rd_start),
      .addr      (nxt_addr[ADDR_W-1:0]),
      .mem_addr  (mem_addr_out),
      .busy      (rd_busy),
      .rec_valid (rec_valid)
   );

   // NOTE: the working buffer has no reset; it is cleared on every frame start and only reaches the outputs through PUBLISH.
   always_ff @(posedge clk_in) begin
      if (state == S_IDLE && frame_start_in) begin
         for (int i = 0; i < NUM_SLOTS; i++) work[i] <= '0;
      end else if (state == S_FILL && !at_end && rec_valid && in_window) begin
         work[count] <= '{id: rec.id, direction: rec.direction, color: rec.color,
                          z: rec.z, y: rec.y, x: rec.x};
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state               <= S_IDLE;
         head                <= '0;
         addr                <= '0;
         count               <= '0;
         t0                  <= '0;
         t_end               <= '0;
         work_vis            <= '0;
         valid_out           <= 1'b0;
         block_x_out         <= '0;
         block_y_out         <= '0;
         block_z_out         <= '0;
         block_color_out     <= '0;
         block_direction_out <= '0;
         block_ID_out        <= '0;
         block_visible_out   <= '0;
`ifdef BLOCK_LOADER_STATS_EN
         overrun_count_out   <= '0;
         scanned_out         <= '0;
         scan_cnt            <= '0;
`endif
      end else begin
         valid_out <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (frame_start_in) begin
                  t0       <= curr_time_in;
                  t_end    <= {1'b0, curr_time_in} + {1'b0, WINDOW};
                  work_vis <= '0;
                  count    <= '0;
                  addr     <= head;
                  state    <= S_SKIP;
               end
            end
            S_SKIP: begin
               if (at_end) begin
                  state <= S_PUBLISH;
               end else if (rec_valid) begin
                  if (rec.tstamp < t0) begin
                     addr <= addr + 1'b1;
                     head <= head + 1'b1;
                  end else begin
                     state <= S_FILL;
                  end
               end
            end
            S_FILL: begin
               if (at_end) begin
                  state <= S_PUBLISH;
               end else if (rec_valid) begin
                  if (in_window) begin
                     work_vis[count] <= 1'b1;
                     count           <= count + 1'b1;
                     addr            <= addr + 1'b1;
                     if (count == CNT_W'(NUM_SLOTS - 1)) state <= S_PUBLISH;
                  end else begin
                     state <= S_PUBLISH;
                  end
               end
            end
            S_PUBLISH: begin
               for (int i = 0; i < NUM_SLOTS; i++) begin
                  block_x_out[i]         <= work[i].x;
                  block_y_out[i]         <= work[i].y;
                  block_z_out[i]         <= work[i].z;
                  block_color_out[i]     <= work[i].color;
                  block_direction_out[i] <= work[i].direction;
                  block_ID_out[i]        <= work[i].id;
               end
               block_visible_out <= work_vis;
               valid_out         <= 1'b1;
               state             <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
`ifdef BLOCK_LOADER_STATS_EN
         if (frame_start_in && state != S_IDLE && overrun_count_out != 16'hFFFF)
            overrun_count_out <= overrun_count_out + 1'b1;
         if (state == S_IDLE && frame_start_in)
            scan_cnt <= '0;
         else if ((state == S_SKIP || state == S_FILL) && rec_valid)
            scan_cnt <= scan_cnt + 1'b1;
         if (state == S_PUBLISH)
            scanned_out <= scan_cnt;
`endif
      end
   end

endmodule

// File: tb/tb_block_window_loader.sv
// Directed bench for block_window_loader with a 32-entry, 2-cycle-latency memory model.
// Optional BLOCK_LOADER_STATS_EN checks are compiled in when the macro is defined.
module tb_block_window_loader;

   localparam int NB = 32;
   localparam int AW = 5;

   logic              clk_in = 1'b0;
   logic              rst_in;
   logic              frame_start_in;
   logic [17:0]       curr_time_in;
   logic [AW-1:0]     mem_addr_out;
   logic [67:0]       mem_data_in;
   logic [11:0][11:0] block_x_out;
   logic [11:0][11:0] block_y_out;
   logic [11:0][13:0] block_z_out;
   logic [11:0]       block_color_out;
   logic [11:0][2:0]  block_direction_out;
   logic [11:0][7:0]  block_ID_out;
   logic [11:0]       block_visible_out;
   logic              busy_out;
   logic              valid_out;
`ifdef BLOCK_LOADER_STATS_EN
   logic [15:0]       overrun_count_out;
   logic [AW:0]       scanned_out;
`endif

   int checks   = 0;
   int failures = 0;
   int vcount   = 0;
   int k;

   logic [67:0]   mem [NB];
   logic [AW-1:0] p1;

   block_window_loader #(
      .NUM_BLOCKS  (NB),
      .ADDR_W      (AW),
      .WINDOW      (18'd1000),
      .MEM_LATENCY (2)
   ) dut (
      .clk_in              (clk_in),
      .rst_in              (rst_in),
      .frame_start_in      (frame_start_in),
      .curr_time_in        (curr_time_in),
      .mem_addr_out        (mem_addr_out),
      .mem_data_in         (mem_data_in),
      .block_x_out         (block_x_out),
      .block_y_out         (block_y_out),
      .block_z_out         (block_z_out),
      .block_color_out     (block_color_out),
      .block_direction_out (block_direction_out),
      .block_ID_out        (block_ID_out),
      .block_visible_out   (block_visible_out),
      .busy_out            (busy_out),
      .valid_out           (valid_out)
`ifdef BLOCK_LOADER_STATS_EN
      ,
      .overrun_count_out   (overrun_count_out),
      .scanned_out         (scanned_out)
`endif
   );

   always #5 clk_in = ~clk_in;

   // Two registered stages: data appears two edges after the address.
   always @(posedge clk_in) begin
      p1          <= mem_addr_out;
      mem_data_in <= mem[p1];
   end

   always @(negedge clk_in) if (valid_out === 1'b1) vcount++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [67:0] mk_rec(input int i, input int t);
      logic [7:0] iv;
      iv = 8'(i);
      return {8'(i + 64), iv[2:0], iv[0], 14'(i * 5 + 2), 12'(i + 7), 12'(i * 3 + 1), 18'(t)};
   endfunction

   function automatic logic [50:0] exp_slot(input int i);
      logic [7:0] iv;
      iv = 8'(i);
      return {12'(i * 3 + 1), 12'(i + 7), 14'(i * 5 + 2), iv[0], iv[2:0], 8'(i + 64), 1'b1};
   endfunction

   function automatic logic [50:0] obs_slot(input int s);
      return {block_x_out[s], block_y_out[s], block_z_out[s], block_color_out[s],
              block_direction_out[s], block_ID_out[s], block_visible_out[s]};
   endfunction

   // kind 0: times 100..2000 then 2500; kind 1: 30 x 500 then 2500; kind 2: all 100
   task automatic load_mem(input int kind);
      for (int i = 0; i < NB; i++) begin
         case (kind)
            0:       mem[i] = mk_rec(i, (i < 20) ? 100 * (i + 1) : 2500);
            1:       mem[i] = mk_rec(i, (i < 30) ? 500 : 2500);
            default: mem[i] = mk_rec(i, 100);
         endcase
      end
   endtask

   task automatic do_reset();
      @(negedge clk_in) rst_in = 1'b1;
      @(negedge clk_in) rst_in = 1'b0;
   endtask

   task automatic start_frame(input int t);
      @(negedge clk_in);
      frame_start_in = 1'b1;
      curr_time_in   = 18'(t);
      @(negedge clk_in);
      frame_start_in = 1'b0;
   endtask

   task automatic wait_valid(input string tag, output int n);
      n = 0;
      while (valid_out !== 1'b1 && n < 400) begin
         @(negedge clk_in);
         n++;
      end
      check({tag, " valid"}, 64'(valid_out), 64'd1);
   endtask

   task automatic check_pub(input string tag, input int first, input int n);
      logic [11:0] v;
      v = '0;
      for (int s = 0; s < n; s++) v[s] = 1'b1;
      check({tag, " visible"}, 64'(block_visible_out), 64'(v));
      for (int s = 0; s < 12; s++)
         check($sformatf("%s slot%0d", tag, s), 64'(obs_slot(s)),
               (s < n) ? 64'(exp_slot(first + s)) : 64'd0);
   endtask

   initial begin
      rst_in         = 1'b1;
      frame_start_in = 1'b0;
      curr_time_in   = '0;
      load_mem(0);
      repeat (3) @(negedge clk_in);
      rst_in = 1'b0;

      // reset state
      check("rst valid", 64'(valid_out), 64'd0);
      check("rst busy", 64'(busy_out), 64'd0);
      check("rst addr", 64'(mem_addr_out), 64'd0);
      check_pub("rst", 0, 0);
`ifdef BLOCK_LOADER_STATS_EN
      check("rst overrun", 64'(overrun_count_out), 64'd0);
`endif

      // frame at t=0: 1 skip-read plus 10 fill reads, window [0,1000) holds 100..900
      start_frame(0);
      check("busy after start", 64'(busy_out), 64'd1);
      wait_valid("t0", k);
      check("latency t0", 64'(k), 64'd35);
      check_pub("t0", 0, 9);
      @(negedge clk_in);
      check("pulse width", 64'(valid_out), 64'd0);
      check("idle after publish", 64'(busy_out), 64'd0);

      // outputs hold while the next scan is in progress
      start_frame(0);
      repeat (10) @(negedge clk_in);
      check("hold busy", 64'(busy_out), 64'd1);
      check("hold visible", 64'(block_visible_out), 64'h1FF);
      check("hold slot0", 64'(obs_slot(0)), 64'(exp_slot(0)));
      wait_valid("hold", k);

      // skip past head, then advance head across frames
      do_reset();
      start_frame(150);
      wait_valid("t150", k);
      check_pub("t150", 1, 10);
      start_frame(1150);
      wait_valid("t1150", k);
      check_pub("t1150", 11, 9);

      // reset mid-FILL discards the scan and rewinds head
      start_frame(0);
      repeat (5) @(negedge clk_in);
      check("midfill busy", 64'(busy_out), 64'd1);
      rst_in = 1'b1;
      @(negedge clk_in);
      rst_in = 1'b0;
      check("midrst busy", 64'(busy_out), 64'd0);
      check("midrst valid", 64'(valid_out), 64'd0);
      check("midrst addr", 64'(mem_addr_out), 64'd0);
      check_pub("midrst", 0, 0);
      start_frame(0);
      wait_valid("after rst", k);
      check_pub("after rst", 0, 9);

      // frame_start while busy is dropped
      do_reset();
      vcount = 0;
      start_frame(0);
      repeat (4) @(negedge clk_in);
      frame_start_in = 1'b1;
      curr_time_in   = 18'd1150;
      @(negedge clk_in);
      frame_start_in = 1'b0;
      wait_valid("overrun", k);
      check_pub("overrun", 0, 9);
      repeat (60) @(negedge clk_in);
      check("overrun pulses", 64'(vcount), 64'd1);
      check("overrun idle", 64'(busy_out), 64'd0);
`ifdef BLOCK_LOADER_STATS_EN
      check("overrun count", 64'(overrun_count_out), 64'd1);
`endif

      // dense memory: stops after 12 accepted records
      do_reset();
      load_mem(1);
      start_frame(0);
      wait_valid("dense", k);
      check_pub("dense", 0, 12);
      check("dense last addr", 64'(mem_addr_out), 64'd11);
`ifdef BLOCK_LOADER_STATS_EN
      check("dense scanned", 64'(scanned_out), 64'd13);
`endif
      repeat (5) @(negedge clk_in);
      check("dense no extra read", 64'(mem_addr_out), 64'd11);

      // t0 beyond every record: head runs to NUM_BLOCKS, empty publish
      do_reset();
      load_mem(2);
      start_frame(3000);
      wait_valid("late", k);
      check_pub("late", 0, 0);
      check("late last addr", 64'(mem_addr_out), 64'd31);
      start_frame(0);
      wait_valid("exhausted", k);
      check("exhausted latency", 64'(k), 64'd2);
      check_pub("exhausted", 0, 0);
      check("exhausted no read", 64'(mem_addr_out), 64'd31);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
